// File: rtl/ifetch_queue.sv
// Instruction fetch queue: single-outstanding imem fetch feeding a DEPTH-entry {pc, instr} FIFO for decode.
// Optional feature: define IFQ_BYPASS_EN to forward an ack straight to decode when the FIFO is empty.
module ifetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [31:0] pc_in,
  output logic        pc_write,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             req_pc_q, req_pc_d;
  logic [DEPTH-1:0][31:0]  pc_mem_q, ins_mem_q;
  logic [PW-1:0]           wptr_q, rptr_q;
  logic [PW:0]             count_q, count_d;
  logic                    fifo_valid, pop, space, acc, push, byp;
  logic [31:0]             push_pc;

  assign fifo_valid = (count_q != '0);
  assign pop        = fifo_valid & id_ready;
  // A same-cycle pop frees a slot for this cycle's fetch.
  assign space      = (count_q - (PW+1)'(pop)) < (PW+1)'(DEPTH);

  always_comb begin
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    imem_req  = 1'b0;
    imem_addr = req_pc_q;
    push_pc   = req_pc_q;
    acc       = 1'b0;
    if (nRST) begin
      case (state_q)
        REQ: begin
          if (space && !flush) begin
            imem_req  = 1'b1;
            imem_addr = pc_in;
            req_pc_d  = pc_in;
            push_pc   = pc_in;
            if (imem_ack) acc = 1'b1;
            else          state_d = WAIT;
          end
        end
        WAIT: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            acc     = 1'b1;
            state_d = REQ;
          end
        end
        DROP: begin
          imem_req = 1'b1;
          if (imem_ack) state_d = REQ;
        end
        default: state_d = REQ;
      endcase
      // REQ never issues under flush; an open request is dropped unless acked now.
      if (flush && state_q != REQ) state_d = imem_ack ? REQ : DROP;
    end
  end

`ifdef IFQ_BYPASS_EN
  assign byp = acc & ~flush & ~fifo_valid & id_ready;
`else
  assign byp = 1'b0;
`endif

  assign push     = acc & ~flush & ~byp;
  assign pc_write = nRST & (flush | acc);
  assign id_valid = fifo_valid | byp;
  assign id_pc    = byp ? push_pc    : pc_mem_q[rptr_q];
  assign id_instr = byp ? imem_rdata : ins_mem_q[rptr_q];
  assign count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q   <= REQ;
      req_pc_q  <= '0;
      pc_mem_q  <= '0;
      ins_mem_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      if (flush) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          pc_mem_q[wptr_q]  <= push_pc;
          ins_mem_q[wptr_q] <= imem_rdata;
          wptr_q            <= wptr_q + 1'b1;
        end
        if (pop) rptr_q <= rptr_q + 1'b1;
        count_q <= count_d;
      end
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: stream, fill, wait states, flush cases, bypass latency.
module tb_ifetch_queue;
`ifdef IFQ_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif
  localparam int LAT = 1 - BYP;

  logic        clk = 1'b0, nRST;
  logic [31:0] pc, tgt;
  logic        pc_write, flush, imem_req, imem_ack, id_valid, id_ready;
  logic [31:0] imem_addr, imem_rdata, id_pc, id_instr;
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  // Memory returns a word derived from the address so data can be checked.
  assign imem_rdata = {16'hCAFE, imem_addr[15:0]};

  // PC register: sequential next-PC, or the redirect target on flush.
  always @(posedge clk or negedge nRST)
    if (!nRST)         pc <= '0;
    else if (pc_write) pc <= flush ? tgt : pc + 32'd4;

  ifetch_queue #(.DEPTH(4)) dut (
    .clk(clk), .nRST(nRST), .pc_in(pc), .pc_write(pc_write), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instr(id_instr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rst();
    nRST = 1'b0; flush = 1'b0; imem_ack = 1'b0; id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0; flush = 1'b0; imem_ack = 1'b1; id_ready = 1'b1; tgt = '0;
    #2;
    chk("rst_req", imem_req, 0);
    chk("rst_pcw", pc_write, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_idv", id_valid, 0);
    chk("rst_idpc", id_pc, 0);
    chk("rst_instr", id_instr, 0);

    // Zero-wait stream
    rst(); id_ready = 1'b1; imem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("str_req", imem_req, 1);
      chk("str_addr", imem_addr, 32'(4*k));
      chk("str_pcw", pc_write, 1);
      chk("str_idv", id_valid, (k >= LAT) ? 32'd1 : 32'd0);
      if (k >= LAT) begin
        chk("str_idpc", id_pc, 32'(4*(k-LAT)));
        chk("str_instr", id_instr, 32'hCAFE0000 | 32'(4*(k-LAT)));
      end
      tick();
    end

    // Fill to full, then one pop
    rst(); id_ready = 1'b0; imem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fill_addr", imem_addr, 32'(4*k));
      chk("fill_pcw", pc_write, 1);
      tick();
    end
    #1;
    chk("full_req", imem_req, 0);
    chk("full_pcw", pc_write, 0);
    chk("full_idv", id_valid, 1);
    chk("full_idpc", id_pc, 0);
    tick(); #1;
    chk("full_req2", imem_req, 0);
    id_ready = 1'b1; #1;
    chk("pop_req", imem_req, 1);
    chk("pop_addr", imem_addr, 32'h10);
    chk("pop_pcw", pc_write, 1);
    tick(); id_ready = 1'b0; #1;
    chk("pop_idpc", id_pc, 32'h4);
    chk("pop_full", imem_req, 0);

    // Wait states on 0x20
    rst(); id_ready = 1'b1; imem_ack = 1'b1;
    repeat (8) tick();
    imem_ack = 1'b0;
    for (int w = 0; w < 3; w++) begin
      #1;
      chk("ws_addr", imem_addr, 32'h20);
      chk("ws_req", imem_req, 1);
      chk("ws_pcw", pc_write, 0);
      tick();
    end
    imem_ack = 1'b1; #1;
    chk("ws_ack_addr", imem_addr, 32'h20);
    chk("ws_ack_pcw", pc_write, 1);
    chk("ws_ack_idv", id_valid, 32'(BYP));
    tick(); #1;
    chk("ws_next_addr", imem_addr, 32'h24);
    chk("ws_next_idv", id_valid, 1);
    chk("ws_next_idpc", id_pc, BYP ? 32'h24 : 32'h20);

    // Flush while 0x30 is outstanding
    repeat (3) tick();
    imem_ack = 1'b0; #1;
    chk("fw_addr", imem_addr, 32'h30);
    tick();
    flush = 1'b1; tgt = 32'h100; #1;
    chk("fw_pcw", pc_write, 1);
    chk("fw_req", imem_req, 1);
    chk("fw_addr2", imem_addr, 32'h30);
    tick(); flush = 1'b0; #1;
    chk("drop_idv", id_valid, 0);
    chk("drop_req", imem_req, 1);
    chk("drop_addr", imem_addr, 32'h30);
    chk("drop_pcw", pc_write, 0);
    tick(); imem_ack = 1'b1; #1;
    chk("drop_ack_pcw", pc_write, 0);
    chk("drop_ack_idv", id_valid, 0);
    tick(); #1;
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_pcw", pc_write, 1);
    chk("redir_idv", id_valid, 32'(BYP));
    if (BYP == 1) chk("redir_idpc_byp", id_pc, 32'h100);
    tick(); imem_ack = 1'b0; #1;
    chk("redir_idv2", id_valid, 32'(LAT));
    if (LAT == 1) chk("redir_idpc", id_pc, 32'h100);
    chk("redir_addr2", imem_addr, 32'h104);

    // Flush with same-cycle ack and pop
    rst(); id_ready = 1'b0; imem_ack = 1'b1;
    repeat (2) tick();
    imem_ack = 1'b0;
    tick();
    flush = 1'b1; tgt = 32'h200; imem_ack = 1'b1; id_ready = 1'b1; #1;
    chk("fa_pcw", pc_write, 1);
    chk("fa_idv", id_valid, 1);
    chk("fa_idpc", id_pc, 0);
    tick(); flush = 1'b0; imem_ack = 1'b0; id_ready = 1'b0; #1;
    chk("fa_idv2", id_valid, 0);
    chk("fa_req", imem_req, 1);
    chk("fa_addr", imem_addr, 32'h200);
    imem_ack = 1'b1;
    tick(); imem_ack = 1'b0; #1;
    chk("fa_newidv", id_valid, 1);
    chk("fa_newpc", id_pc, 32'h200);
    chk("fa_newins", id_instr, 32'hCAFE0200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
